// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode enum and queued command record for the issue stage.
// Optional ALU_ACC_EN adds a per-entry use_acc bit to the command record.
package alu_pkg;

  localparam int ALU_DW = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e           op;
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
`ifdef ALU_ACC_EN
    logic              use_acc;
`endif
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - generic synchronous FIFO with wrap-bit pointers and occupancy output.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged before any same-cycle pop, so a full FIFO never accepts.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - queues ALU commands, drives the combinational ALU and holds its result.
// Define ALU_ACC_EN to add the accumulator and per-command use_acc operand substitution.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [DW-1:0]          cmd_a,
  input  logic [DW-1:0]          cmd_b,
  input  logic                   cmd_use_acc,
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  output logic [2:0]             alu_sel,
  input  logic [DW-1:0]          alu_res,
  input  logic                   alu_zero,
  input  logic                   alu_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DW-1:0]          res_data,
  output logic                   res_zero,
  output logic                   res_cout,
  output logic [$clog2(DEPTH):0] fifo_level
);

  alu_cmd_t cmd_in;
  alu_cmd_t head;
  logic     full;
  logic     empty;
  logic     issue;

  always_comb begin
    cmd_in    = '0;
    cmd_in.op = alu_op_e'(cmd_op);
    cmd_in.a  = cmd_a;
    cmd_in.b  = cmd_b;
`ifdef ALU_ACC_EN
    cmd_in.use_acc = cmd_use_acc;
`endif
  end

`ifndef ALU_ACC_EN
  logic unused_use_acc;
  assign unused_use_acc = cmd_use_acc;
`endif

  assign cmd_ready = !full;
  assign issue     = !empty && (!res_valid || res_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(alu_cmd_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data (cmd_in),
    .pop       (issue),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

`ifdef ALU_ACC_EN
  logic [DW-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= '0;
    else if (issue) acc <= alu_res;
  end
`endif

  // The ALU sees zeros whenever nothing is queued, so stale RAM never leaks out.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = 3'b000;
    if (!empty) begin
      alu_a   = head.a;
      alu_b   = head.b;
      alu_sel = head.op;
`ifdef ALU_ACC_EN
      if (head.use_acc) alu_a = acc;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_cout  <= 1'b0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_data  <= alu_res;
      res_zero  <= alu_zero;
      res_cout  <= alu_cout;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
